serial_sub_ctrl: RTL and testbench
==================================

# serial_sub_ctrl

Bit-serial subtraction controller that time-shares a single `full_sub_df` full-subtractor cell to compute a WIDTH-bit unsigned difference, LSB first, one bit per clock. It latches operands on a start request and feeds the cell one bit pair per cycle, with the registered borrow fed back as the cell's borrow-in. It collects difference bits in a shift register and reports the final difference and borrow-out with a done pulse. It sits between a requesting datapath and the full-subtractor primitive and is the sequencer for that cell.

## Interface

- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `start`  input  1  request a subtraction; sampled only in IDLE.
- `a_in`  input  WIDTH  minuend; sampled on the accepting edge.
- `b_in`  input  WIDTH  subtrahend; sampled on the accepting edge.
- `bi_in`  input  1  initial borrow-in; sampled on the accepting edge.
- `busy`  output  1  high while bits are being processed (RUN).
- `done`  output  1  one-cycle pulse: `diff`/`bout` just updated.
- `diff`  output  WIDTH  result register, (a − b − bi) mod 2^WIDTH.
- `bout`  output  1  final borrow; 1 iff a < b + bi (unsigned).

## Operation

- Internal instance: one `full_sub_df` with ports `a`, `b`, `bi`, `d`, `bo`. It is driven by `a_sr[0]`, `b_sr[0]`, and `brw_q`. This is the only subtraction logic in the block.
- Registers:
  - `a_sr` and `b_sr` are WIDTH-bit operand shift registers.
  - `d_sr` is the WIDTH-bit difference shift register.
  - `brw_q` is the running borrow.
  - `cnt` is a bit counter, $clog2(WIDTH+1) bits.
  - `diff`/`bout` form the result register.
  - `state` holds the FSM state.
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1: load `a_sr`←`a_in`, `b_sr`←`b_in`, `brw_q`←`bi_in`, `cnt`←0, then go to RUN. With `start`=0, stay in IDLE.
  - RUN, each edge:
    - `a_sr`/`b_sr` shift right by 1.
    - `d_sr` ← {cell `d`, `d_sr`[WIDTH-1:1]}.
    - `brw_q` ← cell `bo`.
    - `cnt` ← `cnt`+1.
  - RUN, final edge (`cnt` = WIDTH−1): `diff` ← {cell `d`, `d_sr`[WIDTH-1:1]}, `bout` ← cell `bo`, then go to DONE.
  - DONE: unconditionally go to IDLE on the next edge.
- `start` in RUN or DONE is ignored. It is not queued. A `start` held high is accepted on the first IDLE edge after DONE.
- Operand inputs are don't-care outside the accepting edge. Changes during RUN do not affect the result.
- `diff`/`bout` change only on the RUN→DONE edge and hold until the next completed operation.
- `busy` = (state == RUN) and `done` = (state == DONE). Both are decoded from registered state, with no combinational path from inputs.
- Reset (any time, including mid-RUN):
  - state=IDLE; `busy`=0, `done`=0, `diff`=0, `bout`=0; all shift registers, `cnt` and `brw_q` are cleared.
  - No `done` is produced for an aborted operation.
  - The first edge with `rst_n`=1 may accept `start`.

## Timing

- E0 = edge sampling `start`=1 in IDLE.
- Edges E1..EWIDTH process bits 0..WIDTH−1. The cell sees bit k between E(k) and E(k+1).
- `busy` is high from E0 to EWIDTH (WIDTH cycles).
- `done` is high from EWIDTH to EWIDTH+1 (exactly 1 cycle).
- Next accept edge is at the earliest EWIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- Latency from the start-sampling edge to valid `diff`/`bout` is WIDTH edges.

## Test plan

- WIDTH=8, a=8'h5A, b=8'h3C, bi=0, start 1 cycle → `busy` high for 8 cycles; `done` pulses 1 cycle at E8; `diff`=8'h1E, `bout`=0.
- a=8'h00, b=8'h01, bi=0 → `diff`=8'hFF, `bout`=1. Then a=8'hFF, b=8'hFF, bi=1 → `diff`=8'hFF, `bout`=1. Then a=8'h80, b=8'h7F, bi=1 → `diff`=8'h00, `bout`=0.
- Start a=8'h10, b=8'h01; during RUN pulse `start` and change `a_in`/`b_in` to 8'hAA/8'h55 → result `diff`=8'h0F, `bout`=0; no second operation; `diff` unchanged afterwards.
- `start` held high continuously with fixed operands → `done` pulses every 10 cycles; `busy` low for exactly 2 cycles between runs.
- Assert `rst_n`=0 at E4 of an operation (asynchronously, mid-cycle) → `busy`, `done`, `diff`, `bout` go to 0 immediately; no `done` follows. A new start after release completes normally.
- Exhaustive WIDTH=2 sweep over all a, b, bi (32 cases) → {`bout`, `diff`} equal to (a − b − bi) mod 8 for every case.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor sequencing one full_sub_df cell, LSB first.
// Revision 1.0 - initial release.
`default_nettype none

module full_sub_df (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bi_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             brw_q;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] d_next;

  full_sub_df u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // New difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  assign d_next = {cell_d, d_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      d_sr  <= '0;
      brw_q <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            brw_q <= bi_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          d_sr  <= d_next;
          brw_q <= cell_bo;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= d_next;
            bout  <= cell_bo;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: scoreboard bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2.
// Revision 1.0 - initial release.
`default_nettype none

module tb_serial_sub_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bi8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       bi2 = 1'b0;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  int checks = 0;
  int errors = 0;
  logic [8:0] q8[$];
  logic [2:0] q2[$];

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .bi_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2), .bi_in(bi2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else check("result8", {23'd0, bout8, diff8}, {23'd0, q8.pop_front()});
    end
    if (done2) begin
      if (q2.size() == 0) check("unexpected_done2", 1, 0);
      else check("result2", {29'd0, bout2, diff2}, {29'd0, q2.pop_front()});
    end
  end

  task automatic wait_done8(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) seen = 1'b1;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi, input logic [8:0] exp);
    int  nb;
    bit  seen;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = a; b8 = b; bi8 = bi;
    q8.push_back(exp);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    wait_done8(nb, seen);
    check("done_seen8", 32'(seen), 1);
    check("busy_len8", nb, 8);
    @(negedge clk);
    check("done_pulse8", 32'(done8), 0);
    check("diff_hold8", {23'd0, bout8, diff8}, {23'd0, exp});
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi);
    bit seen;
    int nb;
    @(posedge clk); #1;
    start2 = 1'b1; a2 = a; b2 = b; bi2 = bi;
    q2.push_back(3'({1'b0, a} - {1'b0, b} - {2'b0, bi}));
    @(posedge clk); #1;
    start2 = 1'b0;
    seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (busy2) nb++;
      if (done2) seen = 1'b1;
    end
    if (!seen || nb != 2) check("run2", {nb[30:0], seen}, {31'd2, 1'b1});
  endtask

  initial begin
    int  nb, ndone, cyc, last, nidle;
    bit  seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 0);
    check("rst_done", 32'(done8), 0);
    check("rst_diff", 32'(diff8), 0);
    check("rst_bout", 32'(bout8), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op8(8'h5A, 8'h3C, 1'b0, 9'h01E);
    op8(8'h00, 8'h01, 1'b0, 9'h1FF);
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    op8(8'h80, 8'h7F, 1'b1, 9'h000);

    // start pulsed and operands changed mid-run must not disturb the result
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bi8 = 1'b0;
    q8.push_back(9'h00F);
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
    repeat (2) @(posedge clk);
    #1 start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(nb, seen);
    check("ignored_start_done", 32'(seen), 1);
    repeat (12) @(negedge clk);
    check("ignored_start_hold", {23'd0, bout8, diff8}, 32'h00F);

    // start held high: back-to-back runs every WIDTH+2 cycles
    a8 = 8'h33; b8 = 8'h44; bi8 = 1'b0;
    repeat (3) q8.push_back(9'h1EF);
    @(posedge clk); #1;
    start8 = 1'b1;
    ndone = 0; cyc = 0; last = 0; nidle = 0;
    for (int i = 0; i < 60 && ndone < 3; i++) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        if (ndone > 0) check("done_period", cyc - last, 10);
        last = cyc;
        ndone++;
        if (ndone == 3) start8 = 1'b0;
      end
      if (!busy8 && ndone >= 1 && ndone < 3) nidle++;
    end
    start8 = 1'b0;
    check("held_done_count", ndone, 3);
    check("held_busy_low", nidle, 4);
    repeat (4) @(negedge clk);

    // asynchronous reset mid-run aborts without a done
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h21; bi8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 0);
    check("abort_done", 32'(done8), 0);
    check("abort_diff", 32'(diff8), 0);
    check("abort_bout", 32'(bout8), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op8(8'h5A, 8'h3C, 1'b1, 9'h01D);

    // exhaustive WIDTH=2 sweep
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int bi = 0; bi < 2; bi++)
          op2(2'(a), 2'(b), 1'(bi));

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
